my_reset_sequencer: RTL

- Sits directly downstream of the board clock/reset generator, in the i_sys_clk domain.
- Consumes its system reset (i_sys_rst) and produces ordered, registered reset releases: memory controller first, then bus fabric, then CPU.
- Gates the bus and CPU releases on memory-calibration completion, with a timeout and bounded retries.
- Asserts o_boot_done once the whole system is out of reset.

---
 rtl/my_reset_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/my_reset_sequencer.sv
// Ordered reset release (memory -> bus -> CPU) gated on memory calibration, with timeout/retry.
// Optional CPU warm reset from RUN is enabled by defining RESET_SEQ_SW_RESET_EN.
module my_reset_sequencer #(
  parameter int unsigned MEM_HOLD_CYCLES = 16,
  parameter int unsigned CAL_TIMEOUT     = 65535,
  parameter int unsigned BUS_DELAY       = 8,
  parameter int unsigned CPU_DELAY       = 8,
  parameter int unsigned MAX_RETRIES     = 3
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_mem_calib_done,
  input  logic       i_sw_reset_req,
  output logic       o_mem_rst,
  output logic       o_bus_rst,
  output logic       o_cpu_rst,
  output logic       o_boot_done,
  output logic       o_fail,
  output logic [3:0] o_retry_cnt
);

  localparam logic [15:0] HoldLast   = 16'(MEM_HOLD_CYCLES - 1);
  localparam logic [15:0] CalLast    = 16'(CAL_TIMEOUT - 1);
  localparam logic [15:0] BusLast    = 16'(BUS_DELAY - 1);
  localparam logic [15:0] CpuLast    = 16'(CPU_DELAY - 1);
  localparam logic [3:0]  MaxRetries = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE,
    MEM_HOLD,
    MEM_CAL,
    BUS_REL,
    CPU_REL,
    RUN,
    FAIL
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  retryCnt_q, retryCnt_d;
  logic        memRst_q, busRst_q, cpuRst_q, bootDone_q, fail_q;
  logic        swReq;

`ifdef RESET_SEQ_SW_RESET_EN
  assign swReq = i_sw_reset_req;
`else
  logic unusedSwReq;
  assign swReq       = 1'b0;
  assign unusedSwReq = i_sw_reset_req;
`endif

  always_comb begin
    state_d    = state_q;
    retryCnt_d = retryCnt_q;
    timer_d    = 16'd0;

    unique case (state_q)
      IDLE: state_d = MEM_HOLD;
      MEM_HOLD: begin
        if (timer_q == HoldLast) state_d = MEM_CAL;
      end
      MEM_CAL: begin
        // Calibration completing on the timeout edge still counts as success
        if (i_mem_calib_done) begin
          state_d = BUS_REL;
        end else if (timer_q == CalLast) begin
          retryCnt_d = retryCnt_q + 4'd1;
          state_d    = (retryCnt_d == MaxRetries) ? FAIL : MEM_HOLD;
        end
      end
      BUS_REL: begin
        if (!i_mem_calib_done)    state_d = MEM_HOLD;
        else if (timer_q == BusLast) state_d = CPU_REL;
      end
      CPU_REL: begin
        if (!i_mem_calib_done)    state_d = MEM_HOLD;
        else if (timer_q == CpuLast) state_d = RUN;
      end
      RUN: begin
        if (!i_mem_calib_done) state_d = MEM_HOLD;
        else if (swReq)        state_d = CPU_REL;
      end
      FAIL: state_d = FAIL;
      default: state_d = IDLE;
    endcase

    if (state_d == state_q &&
        (state_q == MEM_HOLD || state_q == MEM_CAL ||
         state_q == BUS_REL  || state_q == CPU_REL)) begin
      timer_d = timer_q + 16'd1;
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as the state
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q    <= IDLE;
      timer_q    <= 16'd0;
      retryCnt_q <= 4'd0;
      memRst_q   <= 1'b1;
      busRst_q   <= 1'b1;
      cpuRst_q   <= 1'b1;
      bootDone_q <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retryCnt_q <= retryCnt_d;
      memRst_q   <= (state_d == IDLE) || (state_d == MEM_HOLD) || (state_d == FAIL);
      busRst_q   <= !((state_d == CPU_REL) || (state_d == RUN));
      cpuRst_q   <= (state_d != RUN);
      bootDone_q <= (state_d == RUN);
      fail_q     <= (state_d == FAIL);
    end
  end

  assign o_mem_rst   = memRst_q;
  assign o_bus_rst   = busRst_q;
  assign o_cpu_rst   = cpuRst_q;
  assign o_boot_done = bootDone_q;
  assign o_fail      = fail_q;
  assign o_retry_cnt = retryCnt_q;

endmodule
